// File: rtl/bridge_if.sv
// CPU-side M-stage access bundle for the device bridge.
// master = pipeline, slave = bridge.
interface bridge_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_write_data;
    logic        dev_write_enable;
    logic [2:0]  dm_mode;
    logic        bridge_stop;
    logic [31:0] cpu_read_result;
    logic        bridge_valid;

    modport master (
        output cpu_addr,
        output cpu_write_data,
        output dev_write_enable,
        output dm_mode,
        output bridge_stop,
        input  cpu_read_result,
        input  bridge_valid
    );

    modport slave (
        input  cpu_addr,
        input  cpu_write_data,
        input  dev_write_enable,
        input  dm_mode,
        input  bridge_stop,
        output cpu_read_result,
        output bridge_valid
    );
endinterface

// File: rtl/bridge.sv
// M-stage bridge to two word-wide devices with timeout,
// plus interrupt staging toward CP0.
module bridge #(
    parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
    parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
    parameter logic [2:0]  WORD_MODE = 3'd3,
    parameter int          TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    bridge_if.slave     cpu,
    output logic [5:0]  hwirq,
    output logic        bus_err,
    output logic [1:0]  dev_addr,
    output logic [31:0] dev_wdata,
    output logic        dev_we,
    output logic        dev0_sel,
    output logic        dev1_sel,
    input  logic        dev0_ack,
    input  logic        dev1_ack,
    input  logic [31:0] dev0_rdata,
    input  logic [31:0] dev1_rdata,
    input  logic [1:0]  dev_irq,
    input  logic [3:0]  ext_irq
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_n;
    logic [3:0]  cnt_q, cnt_n;
    logic [31:0] data_q, data_n;
    logic        err_q, err_n;
    logic        tgt_q, tgt_n;
    logic [1:0]  addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic        we_q, we_n;

    logic        hit0, hit1, dev_access;
    logic        ack_sel;
    logic [31:0] rdata_sel;
    logic [1:0]  dirq_q;
    logic [3:0]  ext_s1, ext_s2;
    logic        unused_bits;

    assign hit0 = cpu.cpu_addr[31:4] == DEV0_BASE[31:4];
    assign hit1 = cpu.cpu_addr[31:4] == DEV1_BASE[31:4];
    assign dev_access = (cpu.dm_mode != 3'd0) && (hit0 || hit1);

    assign ack_sel   = tgt_q ? dev1_ack : dev0_ack;
    assign rdata_sel = tgt_q ? dev1_rdata : dev0_rdata;
    assign unused_bits = ^{cpu.cpu_addr[1:0]};

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        data_n  = data_q;
        err_n   = 1'b0;
        tgt_n   = tgt_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        we_n    = we_q;
        unique case (state_q)
            IDLE: begin
                if (!cpu.bridge_stop && dev_access) begin
                    if (cpu.dm_mode == WORD_MODE) begin
                        state_n = REQ;
                        cnt_n   = 4'd0;
                        tgt_n   = !hit0;
                        addr_n  = cpu.cpu_addr[3:2];
                        wdata_n = cpu.cpu_write_data;
                        we_n    = cpu.dev_write_enable;
                    end else begin
                        // Sub-word device accesses complete without a bus cycle
                        state_n = DONE;
                        data_n  = 32'd0;
                        we_n    = 1'b0;
                    end
                end
            end
            REQ: begin
                if (cpu.bridge_stop) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else if (ack_sel) begin
                    state_n = DONE;
                    cnt_n   = 4'd0;
                    data_n  = we_q ? 32'd0 : rdata_sel;
                end else if (cnt_q == 4'(TIMEOUT - 1)) begin
                    state_n = DONE;
                    cnt_n   = 4'd0;
                    data_n  = 32'd0;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
            tgt_q   <= 1'b0;
            addr_q  <= 2'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            data_q  <= data_n;
            err_q   <= err_n;
            tgt_q   <= tgt_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            we_q    <= we_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dirq_q <= 2'd0;
            ext_s1 <= 4'd0;
            ext_s2 <= 4'd0;
        end else begin
            dirq_q <= dev_irq;
            ext_s1 <= ext_irq;
            ext_s2 <= ext_s1;
        end
    end

    // Outputs are gated by rst so the reset cycle itself looks idle
    always_comb begin
        dev0_sel            = 1'b0;
        dev1_sel            = 1'b0;
        dev_we              = 1'b0;
        bus_err             = 1'b0;
        cpu.cpu_read_result = 32'd0;
        cpu.bridge_valid    = !dev_access;
        hwirq               = 6'd0;
        if (!rst) begin
            hwirq = {ext_s2, dirq_q};
            unique case (state_q)
                IDLE: begin
                    cpu.bridge_valid = !dev_access;
                end
                REQ: begin
                    dev0_sel         = !tgt_q;
                    dev1_sel         = tgt_q;
                    dev_we           = we_q;
                    cpu.bridge_valid = cpu.bridge_stop;
                end
                DONE: begin
                    bus_err             = err_q;
                    cpu.cpu_read_result = data_q;
                    cpu.bridge_valid    = 1'b1;
                end
                default: begin
                    cpu.bridge_valid = 1'b1;
                end
            endcase
        end
    end

    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;
endmodule

// File: tb/tb_bridge.sv
// Scoreboard bench for bridge: driver pushes expected load results,
// a negedge monitor pops them whenever the bridge lets the CPU advance.
module tb_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hwirq;
    logic        bus_err;
    logic [1:0]  dev_addr;
    logic [31:0] dev_wdata;
    logic        dev_we;
    logic        dev0_sel, dev1_sel;
    logic        dev0_ack, dev1_ack;
    logic [31:0] dev0_rdata, dev1_rdata;
    logic [1:0]  dev_irq;
    logic [3:0]  ext_irq;

    bridge_if cpu ();

    bridge dut (
        .clk        (clk),
        .rst        (rst),
        .cpu        (cpu),
        .hwirq      (hwirq),
        .bus_err    (bus_err),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_we     (dev_we),
        .dev0_sel   (dev0_sel),
        .dev1_sel   (dev1_sel),
        .dev0_ack   (dev0_ack),
        .dev1_ack   (dev1_ack),
        .dev0_rdata (dev0_rdata),
        .dev1_rdata (dev1_rdata),
        .dev_irq    (dev_irq),
        .ext_irq    (ext_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic active = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (active && cpu.bridge_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: got response %h expected none",
                         cpu.cpu_read_result);
            end else begin
                e = sb.pop_front();
                check("read_result", cpu.cpu_read_result, e.data);
                check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
            end
        end
    end

    // Device model: ack after lat sel cycles, lat == 0 never acks
    int lat0 = 1, lat1 = 1, c0 = 0, c1 = 0;
    always @(negedge clk) begin
        if (dev0_sel) begin
            c0++;
            dev0_ack = (lat0 != 0) && (c0 >= lat0);
        end else begin
            c0 = 0;
            dev0_ack = 1'b0;
        end
        if (dev1_sel) begin
            c1++;
            dev1_ack = (lat1 != 0) && (c1 >= lat1);
        end else begin
            c1 = 0;
            dev1_ack = 1'b0;
        end
    end

    task automatic txn(input logic [31:0] a, input logic [31:0] wd,
                       input logic we, input logic [2:0] m,
                       input logic [31:0] ed, input logic ee,
                       output int low, output int s0, output int s1,
                       output int ec, output logic [1:0] ca,
                       output logic cw, output logic [31:0] cwd);
        exp_t e;
        bit done;
        low = 0; s0 = 0; s1 = 0; ec = 0;
        ca = 2'd0; cw = 1'b0; cwd = 32'd0;
        done = 1'b0;
        @(posedge clk);
        #1;
        cpu.cpu_addr = a;
        cpu.cpu_write_data = wd;
        cpu.dev_write_enable = we;
        cpu.dm_mode = m;
        e.data = ed;
        e.err = ee;
        sb.push_back(e);
        active = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dev0_sel || dev1_sel) begin
                ca = dev_addr;
                cw = dev_we;
                cwd = dev_wdata;
            end
            s0 += int'(dev0_sel);
            s1 += int'(dev1_sel);
            ec += int'(bus_err);
            if (cpu.bridge_valid) begin
                done = 1'b1;
                break;
            end
            low++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL txn_timeout: addr %h got no valid expected valid", a);
        end
        @(posedge clk);
        #1;
        active = 1'b0;
        cpu.dm_mode = 3'd0;
        cpu.dev_write_enable = 1'b0;
        cpu.cpu_addr = 32'd0;
    endtask

    int low, s0, s1, ec;
    logic [1:0] ca;
    logic cw;
    logic [31:0] cwd;

    initial begin
        rst = 1'b1;
        cpu.cpu_addr = 32'd0;
        cpu.cpu_write_data = 32'd0;
        cpu.dev_write_enable = 1'b0;
        cpu.dm_mode = 3'd0;
        cpu.bridge_stop = 1'b0;
        dev0_ack = 1'b0;
        dev1_ack = 1'b0;
        dev0_rdata = 32'd0;
        dev1_rdata = 32'd0;
        dev_irq = 2'd0;
        ext_irq = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, cpu.bridge_valid}, 32'd1);
        check("rst_rdata", cpu.cpu_read_result, 32'd0);
        check("rst_sel", {30'd0, dev1_sel, dev0_sel}, 32'd0);
        check("rst_hwirq", {26'd0, hwirq}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Word load, single-cycle ack
        lat0 = 1;
        dev0_rdata = 32'h1234_5678;
        txn(32'h7F04, 32'd0, 1'b0, 3'd3, 32'h1234_5678, 1'b0,
            low, s0, s1, ec, ca, cw, cwd);
        check("ld_low", low, 2);
        check("ld_sel0", s0, 1);
        check("ld_sel1", s1, 0);
        check("ld_addr", {30'd0, ca}, 32'd1);

        // Word store, ack on third sel cycle
        lat1 = 3;
        dev1_rdata = 32'hDEAD_BEEF;
        txn(32'h7F18, 32'hCAFE_F00D, 1'b1, 3'd3, 32'd0, 1'b0,
            low, s0, s1, ec, ca, cw, cwd);
        check("st_sel1", s1, 3);
        check("st_sel0", s0, 0);
        check("st_we", {31'd0, cw}, 32'd1);
        check("st_wdata", cwd, 32'hCAFE_F00D);
        check("st_addr", {30'd0, ca}, 32'd2);
        check("st_low", low, 4);

        // Timeout
        lat0 = 0;
        txn(32'h7F00, 32'd0, 1'b0, 3'd3, 32'd0, 1'b1,
            low, s0, s1, ec, ca, cw, cwd);
        check("to_sel0", s0, 15);
        check("to_err_cycles", ec, 1);
        check("to_low", low, 16);

        // Non-device word load
        txn(32'h0000_1000, 32'd0, 1'b0, 3'd3, 32'd0, 1'b0,
            low, s0, s1, ec, ca, cw, cwd);
        check("nd_low", low, 0);
        check("nd_sel", s0 + s1, 0);

        // Byte-mode device access
        txn(32'h7F10, 32'd0, 1'b0, 3'd1, 32'd0, 1'b0,
            low, s0, s1, ec, ca, cw, cwd);
        check("byte_low", low, 1);
        check("byte_sel1", s1, 0);

        // Flush in second REQ cycle
        lat0 = 0;
        @(posedge clk);
        #1;
        cpu.cpu_addr = 32'h7F00;
        cpu.dm_mode = 3'd3;
        @(negedge clk);
        check("stp_idle_valid", {31'd0, cpu.bridge_valid}, 32'd0);
        @(negedge clk);
        check("stp_req_sel0", {31'd0, dev0_sel}, 32'd1);
        @(posedge clk);
        #1 cpu.bridge_stop = 1'b1;
        @(negedge clk);
        check("stp_valid", {31'd0, cpu.bridge_valid}, 32'd1);
        @(posedge clk);
        #1;
        cpu.bridge_stop = 1'b0;
        cpu.dm_mode = 3'd0;
        cpu.cpu_addr = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stp_sel0", {31'd0, dev0_sel}, 32'd0);
            check("stp_bus_err", {31'd0, bus_err}, 32'd0);
            check("stp_rdata", cpu.cpu_read_result, 32'd0);
        end

        lat0 = 1;
        dev0_rdata = 32'hA5A5_0001;
        txn(32'h7F0C, 32'd0, 1'b0, 3'd3, 32'hA5A5_0001, 1'b0,
            low, s0, s1, ec, ca, cw, cwd);
        check("post_low", low, 2);
        check("post_addr", {30'd0, ca}, 32'd3);

        // dev1 minimum-latency load
        lat1 = 1;
        dev1_rdata = 32'h0BAD_F00D;
        txn(32'h7F14, 32'd0, 1'b0, 3'd3, 32'h0BAD_F00D, 1'b0,
            low, s0, s1, ec, ca, cw, cwd);
        check("d1_low", low, 2);
        check("d1_sel0", s0, 0);

        // Reset during REQ
        lat0 = 0;
        @(posedge clk);
        #1;
        cpu.cpu_addr = 32'h7F00;
        cpu.dm_mode = 3'd3;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cpu.dm_mode = 3'd0;
        cpu.cpu_addr = 32'd0;
        @(negedge clk);
        check("mrst_sel0", {31'd0, dev0_sel}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_sel0_after", {31'd0, dev0_sel}, 32'd0);
        check("mrst_bus_err", {31'd0, bus_err}, 32'd0);
        check("mrst_valid", {31'd0, cpu.bridge_valid}, 32'd1);

        // Interrupt staging
        @(posedge clk);
        #1;
        ext_irq = 4'b0010;
        dev_irq = 2'b01;
        @(negedge clk);
        check("irq_t0", {26'd0, hwirq}, 32'd0);
        @(negedge clk);
        check("irq_t1", {26'd0, hwirq}, 32'h01);
        @(negedge clk);
        check("irq_t2", {26'd0, hwirq}, 32'h09);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("irq_rst", {26'd0, hwirq}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ext_irq = 4'd0;
        dev_irq = 2'd0;
        @(negedge clk);
        check("irq_cleared", {26'd0, hwirq}, 32'd0);

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
